// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with synchroniser, false-start rejection, parity/framing
// error flags and a valid/ready output stage that reports dropped frames as overrun.
module uart_rx_ext #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = 4;

   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic                 sync1_q, rxs_q, prev_q;
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 overrun_q, overrun_d;

   logic rx_fall;
   logic accept;
   logic par_calc;

   assign rx_fall  = prev_q & ~rxs_q;
   assign accept   = valid_q & rx_ready_i;
   assign par_calc = (^shift_q) ^ rxs_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      done_d     = 1'b0;
      data_d     = data_q;
      valid_d    = valid_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      overrun_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rx_fall) state_d = ST_START;
         end
         ST_START: begin
            // Restarting cnt at the mid-start sample puts every later sample at mid-bit.
            if (cnt_q == CNT_MID) begin
               cnt_d  = '0;
               idx_d  = '0;
               perr_d = 1'b0;
               ferr_d = 1'b0;
               state_d = rxs_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               perr_d  = (PARITY == 1) ? ~par_calc : par_calc;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!rxs_q) ferr_d = 1'b1;
               if (idx_q == IDX_STOP_LAST) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // A completed frame only lands if the output slot is free or being emptied now.
      if (done_q) begin
         if (!valid_q || accept) begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q;
            valid_d    = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         prev_q     <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         done_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sync1_q    <= rx_i;
         rxs_q      <= sync1_q;
         prev_q     <= rxs_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         done_q     <= done_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         overrun_q  <= overrun_d;
      end
   end

   assign rx_data_o    = data_q;
   assign rx_valid_o   = valid_q;
   assign parity_err_o = perr_out_q;
   assign frame_err_o  = ferr_out_q;
   assign overrun_o    = overrun_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three instances (8N1, 7E1, 8N2) at 10 clocks per bit, a table of
// frames plus hand-written corner sequences, checked against a queue of expected words.
module tb_uart_rx_ext;

   typedef struct {
      int         sel;
      logic [8:0] data;
      bit         parFlip;
      logic [1:0] stops;
      logic [8:0] expData;
      bit         expPerr;
      bit         expFerr;
   } vec_t;

   typedef struct {
      logic [8:0] data;
      bit         perr;
      bit         ferr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxLine = 1'b1;
   logic rdyLine = 1'b1;
   int   sel = 0;
   int   cyc = 0;

   logic       rx0, rx1, rx2, rdy0, rdy1, rdy2;
   logic [7:0] data0, data2;
   logic [6:0] data1;
   logic       valid0, valid1, valid2, perr0, perr1, perr2;
   logic       ferr0, ferr1, ferr2, ov0, ov1, ov2, busy0, busy1, busy2;

   logic [8:0] monData;
   logic       monValid, monPerr, monFerr, monOv, monBusy;

   int   errors = 0;
   int   checks = 0;
   exp_t expQ[$];
   int   popCount = 0;
   int   ovCount = 0;
   int   riseCyc = 0;
   int   startCyc = 0;
   int   runLen = 0;
   int   lastRun = 0;
   logic prevValid = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign rx0  = (sel == 0) ? rxLine : 1'b1;
   assign rx1  = (sel == 1) ? rxLine : 1'b1;
   assign rx2  = (sel == 2) ? rxLine : 1'b1;
   assign rdy0 = (sel == 0) ? rdyLine : 1'b1;
   assign rdy1 = (sel == 1) ? rdyLine : 1'b1;
   assign rdy2 = (sel == 2) ? rdyLine : 1'b1;

   uart_rx_ext #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
      .clk_i(clk), .rst_i(rst), .rx_i(rx0), .rx_data_o(data0), .rx_valid_o(valid0),
      .rx_ready_i(rdy0), .parity_err_o(perr0), .frame_err_o(ferr0), .overrun_o(ov0), .busy_o(busy0));

   uart_rx_ext #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut7e1 (
      .clk_i(clk), .rst_i(rst), .rx_i(rx1), .rx_data_o(data1), .rx_valid_o(valid1),
      .rx_ready_i(rdy1), .parity_err_o(perr1), .frame_err_o(ferr1), .overrun_o(ov1), .busy_o(busy1));

   uart_rx_ext #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut8n2 (
      .clk_i(clk), .rst_i(rst), .rx_i(rx2), .rx_data_o(data2), .rx_valid_o(valid2),
      .rx_ready_i(rdy2), .parity_err_o(perr2), .frame_err_o(ferr2), .overrun_o(ov2), .busy_o(busy2));

   always_comb begin
      monData  = {1'b0, data0};
      monValid = valid0;
      monPerr  = perr0;
      monFerr  = ferr0;
      monOv    = ov0;
      monBusy  = busy0;
      case (sel)
         1: begin
            monData = {2'b00, data1}; monValid = valid1; monPerr = perr1;
            monFerr = ferr1; monOv = ov1; monBusy = busy1;
         end
         2: begin
            monData = {1'b0, data2}; monValid = valid2; monPerr = perr2;
            monFerr = ferr2; monOv = ov2; monBusy = busy2;
         end
         default: ;
      endcase
   end

   function automatic int nbOf(input int s);
      return (s == 1) ? 7 : 8;
   endfunction

   function automatic int parOf(input int s);
      return (s == 1) ? 2 : 0;
   endfunction

   function automatic int nsOf(input int s);
      return (s == 2) ? 2 : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted word is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (monValid && !prevValid) riseCyc = cyc;
         if (monValid) runLen++;
         else if (prevValid) begin
            lastRun = runLen;
            runLen  = 0;
         end
         if (monOv) ovCount++;
         if (monValid && rdyLine) begin
            popCount++;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got data 0x%0h, expected no word", monData);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               chk("word_data", 32'(monData), 32'(e.data));
               chk("word_parity_err", 32'(monPerr), 32'(e.perr));
               chk("word_frame_err", 32'(monFerr), 32'(e.ferr));
            end
         end
         prevValid = monValid;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendFrame(input int s, input logic [8:0] d, input bit parFlip, input logic [1:0] stops);
      logic p;
      p = 1'b0;
      startCyc = cyc;
      rxLine = 1'b0;
      tick(10);
      for (int i = 0; i < nbOf(s); i++) begin
         rxLine = d[i];
         p = p ^ d[i];
         tick(10);
      end
      if (parOf(s) != 0) begin
         rxLine = ((parOf(s) == 1) ? ~p : p) ^ parFlip;
         tick(10);
      end
      for (int i = 0; i < nsOf(s); i++) begin
         rxLine = stops[i];
         tick(10);
      end
      rxLine = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      sel = v.sel;
      rdyLine = 1'b1;
      e.data = v.expData;
      e.perr = v.expPerr;
      e.ferr = v.expFerr;
      expQ.push_back(e);
      sendFrame(v.sel, v.data, v.parFlip, v.stops);
      tick(20);
   endtask

   task automatic checkOutput(input vec_t v);
      int n;
      int lat;
      int latExp;
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL word_timeout: %0d words outstanding, expected 0", expQ.size());
         expQ.delete();
      end
      lat    = riseCyc - startCyc - 1;
      latExp = 3 + (nbOf(v.sel) + ((parOf(v.sel) != 0) ? 1 : 0) + nsOf(v.sel)) * 10 + 5;
      checks++;
      if (lat < latExp - 2 || lat > latExp + 2) begin
         errors++;
         $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-2", lat, latExp);
      end
      chk("valid_width", 32'(lastRun), 32'd1);
   endtask

   vec_t vecs[8];
   vec_t hv;

   initial begin
      int popBefore;
      int ovBefore;
      bit sawBusy;

      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int popBefore;
      int ovBefore;
      bit sawBusy;

      vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
      vecs[2] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
      vecs[3] = '{1, 9'h035, 1'b0, 2'b11, 9'h035, 1'b0, 1'b0};
      vecs[4] = '{1, 9'h035, 1'b1, 2'b11, 9'h035, 1'b1, 1'b0};
      vecs[5] = '{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
      vecs[6] = '{2, 9'h0C3, 1'b0, 2'b01, 9'h0C3, 1'b0, 1'b1};
      vecs[7] = '{2, 9'h081, 1'b0, 2'b11, 9'h081, 1'b0, 1'b0};

      rst = 1'b1;
      tick(3);
      chk("reset_outputs_8n1", {22'd0, data0, valid0, perr0, ferr0, ov0, busy0}, 32'd0);
      chk("reset_outputs_7e1", {23'd0, data1, valid1, perr1, ferr1, ov1, busy1}, 32'd0);
      chk("reset_outputs_8n2", {22'd0, data2, valid2, perr2, ferr2, ov2, busy2}, 32'd0);
      rst = 1'b0;
      tick(5);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end
      chk("no_overrun_with_ready", 32'(ovCount), 32'd0);

      // Break: one word of zeros with a framing error, then nothing until a fresh edge.
      sel = 0;
      rdyLine = 1'b1;
      popBefore = popCount;
      expQ.push_back('{9'h000, 1'b0, 1'b1});
      rxLine = 1'b0;
      tick(150);
      rxLine = 1'b1;
      tick(60);
      chk("break_word_count", 32'(popCount - popBefore), 32'd1);
      chk("break_queue_empty", 32'(expQ.size()), 32'd0);
      hv = '{0, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};
      applyStimulus(hv);
      checkOutput(hv);

      // False start: a 3-clock glitch must not produce a word.
      popBefore = popCount;
      sawBusy = 1'b0;
      rxLine = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         if (monBusy) sawBusy = 1'b1;
      end
      rxLine = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (monBusy) sawBusy = 1'b1;
      end
      chk("false_start_busy_seen", 32'(sawBusy), 32'd1);
      chk("false_start_busy_cleared", 32'(monBusy), 32'd0);
      tick(20);
      chk("false_start_no_valid", 32'(monValid), 32'd0);
      chk("false_start_no_word", 32'(popCount - popBefore), 32'd0);

      // Overrun: consumer stalled, second frame is dropped.
      sel = 0;
      rdyLine = 1'b0;
      ovBefore = ovCount;
      expQ.push_back('{9'h011, 1'b0, 1'b0});
      sendFrame(0, 9'h011, 1'b0, 2'b11);
      tick(5);
      sendFrame(0, 9'h022, 1'b0, 2'b11);
      tick(10);
      chk("overrun_pulses", 32'(ovCount - ovBefore), 32'd1);
      chk("overrun_held_data", 32'(monData), 32'h011);
      chk("overrun_held_valid", 32'(monValid), 32'd1);
      chk("overrun_not_accepted", 32'(expQ.size()), 32'd1);
      rdyLine = 1'b1;
      tick(3);
      chk("overrun_valid_falls", 32'(monValid), 32'd0);
      chk("overrun_queue_drained", 32'(expQ.size()), 32'd0);

      // Reset during data bit 3 abandons the frame.
      sel = 2;
      rdyLine = 1'b1;
      popBefore = popCount;
      rxLine = 1'b0;
      tick(10);
      rxLine = 1'b1;
      tick(35);
      chk("busy_before_reset", 32'(busy2), 32'd1);
      rst = 1'b1;
      tick(1);
      chk("mid_frame_reset_outputs", {22'd0, data2, valid2, perr2, ferr2, ov2, busy2}, 32'd0);
      rst = 1'b0;
      tick(120);
      chk("abandoned_frame_no_word", 32'(popCount - popBefore), 32'd0);
      hv = '{2, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
      applyStimulus(hv);
      checkOutput(hv);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
